// File: rtl/bitrev_job_ctrl.sv
// Job sequencer for the bit-reverse subsystem: streams a job's source words
// into the accelerator, starts it, supervises the done wait and reads results back.
module bitrev_job_ctrl #(
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 10,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              job_valid_i,
    input  logic [LEN_W-1:0]  job_len_i,
    output logic              job_ready_o,
    output logic              job_done_o,
    output logic              err_timeout_o,
    output logic              busy_o,
    input  logic [DATA_W-1:0] src_data_i,
    input  logic              src_valid_i,
    output logic              src_ready_o,
    output logic [DATA_W-1:0] res_data_o,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [DATA_W-1:0] acc_din_o,
    output logic              acc_write_o,
    output logic              acc_start_o,
    output logic              acc_read_o,
    input  logic [DATA_W-1:0] acc_dout_i,
    input  logic              acc_done_i
);
    localparam int            TW   = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_WAIT, S_READ, S_RDWAIT, S_DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic               rdw_q, rdw_d;
    logic [DATA_W-1:0]  acc_din_q, acc_din_d;
    logic               acc_write_q, acc_write_d;
    logic               acc_start_q, acc_start_d;
    logic               acc_read_q, acc_read_d;
    logic [DATA_W-1:0]  res_data_q, res_data_d;
    logic               res_valid_q, res_valid_d;
    logic               job_done_q, job_done_d;
    logic               err_q, err_d;

    logic job_acc, src_hs, res_hs, rd_issue, capture, timeout_hit;

    assign job_acc     = job_valid_i & (state_q == S_IDLE);
    assign src_hs      = src_valid_i & (state_q == S_LOAD);
    assign res_hs      = res_valid_q & res_ready_i;
    assign rd_issue    = (state_q == S_READ) & (~res_valid_q | res_ready_i);
    // acc_dout_i lands the cycle after the read pulse, so capture on RD_WAIT's second cycle
    assign capture     = (state_q == S_RDWAIT) & rdw_q;
    assign timeout_hit = (state_q == S_WAIT) & ~acc_done_i & (timer_q == TMAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            timer_q     <= '0;
            rdw_q       <= 1'b0;
            acc_din_q   <= '0;
            acc_write_q <= 1'b0;
            acc_start_q <= 1'b0;
            acc_read_q  <= 1'b0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            job_done_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            timer_q     <= timer_d;
            rdw_q       <= rdw_d;
            acc_din_q   <= acc_din_d;
            acc_write_q <= acc_write_d;
            acc_start_q <= acc_start_d;
            acc_read_q  <= acc_read_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            job_done_q  <= job_done_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        rdw_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (job_acc && job_len_i != '0) begin
                    len_d   = job_len_i;
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (src_hs) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    if (cnt_q == len_q - LEN_W'(1)) state_d = S_START;
                end
            end
            S_START: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // done has priority over an expiry in the same cycle
                if (acc_done_i) begin
                    cnt_d   = '0;
                    state_d = S_READ;
                end else if (timer_q == TMAX) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_READ: begin
                if (rd_issue) state_d = S_RDWAIT;
            end
            S_RDWAIT: begin
                if (!rdw_q) begin
                    rdw_d = 1'b1;
                end else begin
                    cnt_d   = cnt_q + LEN_W'(1);
                    state_d = (cnt_q + LEN_W'(1) == len_q) ? S_DRAIN : S_READ;
                end
            end
            S_DRAIN: begin
                if (!res_valid_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        acc_din_d   = src_hs ? src_data_i : acc_din_q;
        acc_write_d = src_hs;
        acc_start_d = (state_q == S_START);
        acc_read_d  = rd_issue;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        if (capture) begin
            res_data_d  = acc_dout_i;
            res_valid_d = 1'b1;
        end else if (res_hs) begin
            res_valid_d = 1'b0;
        end
        job_done_d = (job_acc && job_len_i == '0) | timeout_hit |
                     ((state_q == S_DRAIN) && !res_valid_q);
        err_d = err_q;
        if (job_acc)     err_d = 1'b0;
        if (timeout_hit) err_d = 1'b1;
    end

    assign job_ready_o   = (state_q == S_IDLE);
    assign busy_o        = (state_q != S_IDLE);
    assign src_ready_o   = (state_q == S_LOAD);
    assign job_done_o    = job_done_q;
    assign err_timeout_o = err_q;
    assign res_data_o    = res_data_q;
    assign res_valid_o   = res_valid_q;
    assign acc_din_o     = acc_din_q;
    assign acc_write_o   = acc_write_q;
    assign acc_start_o   = acc_start_q;
    assign acc_read_o    = acc_read_q;
endmodule
